// File: rtl/kj_pkg.sv
// Shared K/J line definitions for the sync transmitter and receiver-side checkers.
package kj_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        LAST_J
    } kj_state_e;

    // Line symbol packed as {k, j}
    typedef logic [1:0] kj_sym_t;

    localparam kj_sym_t SYM_K   = 2'b10;
    localparam kj_sym_t SYM_J   = 2'b01;
    localparam kj_sym_t SYM_SE0 = 2'b00;

    localparam int unsigned SYNC_LEN = 8;

    // Index 0 is sent first: K J K J K J K K
    localparam logic [SYNC_LEN-1:0][1:0] SYNC_PATTERN =
        {SYM_K, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K};

    function automatic kj_sym_t toggle_sym(kj_sym_t s);
        return {s[0], s[1]};
    endfunction

endpackage

// File: rtl/kj_sync_tx_if.sv
// Request/response and line bundle between a frame requester and kj_sync_tx.
interface kj_sync_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              tx_k;
    logic              tx_j;
    logic              tx_en;

    modport master (
        output start, data,
        input  busy, done, tx_k, tx_j, tx_en
    );

    modport slave (
        input  start, data,
        output busy, done, tx_k, tx_j, tx_en
    );
endinterface

// File: rtl/kj_nrzi_stuffer.sv
// NRZI encoder with bit stuffing: holds the line reference and the run-of-ones count.
module kj_nrzi_stuffer
    import kj_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    init,
    input  logic    valid,
    input  logic    bit_in,
    output logic    stuff_c,
    output kj_sym_t sym_c
);
    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

    logic [ONES_W-1:0] ones_q;
    kj_sym_t           line_q;
    logic              eff_bit;

    // A pending stuff forces a 0 (toggle) regardless of the payload bit.
    always_comb begin
        stuff_c = (ones_q == ONES_W'(STUFF_LEN));
        eff_bit = bit_in & ~stuff_c;
        sym_c   = eff_bit ? line_q : toggle_sym(line_q);
    end

    // SYNC always ends on K, so init seeds the NRZI reference with K.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
            line_q <= SYM_K;
        end else if (init) begin
            ones_q <= '0;
            line_q <= SYM_K;
        end else if (valid) begin
            line_q <= sym_c;
            ones_q <= eff_bit ? ones_q + ONES_W'(1) : '0;
        end
    end

endmodule

// File: rtl/kj_sync_tx.sv
// K/J sync transmitter: SYNC pattern, NRZI bit-stuffed payload (LSB first), SE0 EOP, then J.
module kj_sync_tx
    import kj_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned EOP_SE0   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    kj_sync_tx_if.slave bus
);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned EOP_W  = $clog2(EOP_SE0 + 1);
    localparam int unsigned SIDX_W = $clog2(SYNC_LEN);

    kj_state_e         state_q,    state_d;
    logic [SIDX_W-1:0] sync_idx_q, sync_idx_d;
    logic [EOP_W-1:0]  eop_cnt_q,  eop_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    kj_sym_t           sym_q,      sym_d;
    logic              tx_en_q,    tx_en_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic    stf_init_c;
    logic    stf_valid_c;
    logic    stf_bit_c;
    logic    stuff_c;
    kj_sym_t stf_sym_c;

    kj_nrzi_stuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuffer (
        .clk     (CLK),
        .rst_n   (RST),
        .init    (stf_init_c),
        .valid   (stf_valid_c),
        .bit_in  (stf_bit_c),
        .stuff_c (stuff_c),
        .sym_c   (stf_sym_c)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sync_idx_q <= '0;
            eop_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sym_q      <= SYM_J;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_idx_q <= sync_idx_d;
            eop_cnt_q  <= eop_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sym_q      <= sym_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state computes the symbol driven during the following cycle.
    always_comb begin
        state_d     = state_q;
        sync_idx_d  = sync_idx_q;
        eop_cnt_d   = eop_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        sym_d       = sym_q;
        tx_en_d     = tx_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stf_init_c  = 1'b0;
        stf_valid_c = 1'b0;
        stf_bit_c   = shreg_q[0];

        case (state_q)
            IDLE: begin
                sym_d   = SYM_J;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    state_d    = SYNC;
                    sync_idx_d = '0;
                    bit_cnt_d  = '0;
                    eop_cnt_d  = '0;
                    shreg_d    = bus.data;
                    sym_d      = SYNC_PATTERN[0];
                    tx_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    stf_init_c = 1'b1;
                end
            end

            SYNC: begin
                if (sync_idx_q == SIDX_W'(SYNC_LEN - 1)) begin
                    // Ones count is zero here, so the first payload bit is never a stuff.
                    state_d     = DATA;
                    stf_valid_c = 1'b1;
                    sym_d       = stf_sym_c;
                    shreg_d     = shreg_q >> 1;
                    bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                end else begin
                    sync_idx_d = sync_idx_q + SIDX_W'(1);
                    sym_d      = SYNC_PATTERN[sync_idx_q + SIDX_W'(1)];
                end
            end

            DATA: begin
                if (stuff_c) begin
                    stf_valid_c = 1'b1;
                    sym_d       = stf_sym_c;
                end else if (bit_cnt_q != BIT_W'(DATA_W)) begin
                    stf_valid_c = 1'b1;
                    sym_d       = stf_sym_c;
                    shreg_d     = shreg_q >> 1;
                    bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                end else begin
                    state_d   = EOP;
                    eop_cnt_d = '0;
                    sym_d     = SYM_SE0;
                end
            end

            EOP: begin
                if (eop_cnt_q == EOP_W'(EOP_SE0 - 1)) begin
                    state_d = LAST_J;
                    sym_d   = SYM_J;
                end else begin
                    eop_cnt_d = eop_cnt_q + EOP_W'(1);
                    sym_d     = SYM_SE0;
                end
            end

            LAST_J: begin
                state_d = IDLE;
                sym_d   = SYM_J;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                sym_d   = SYM_J;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx_k  = sym_q[1];
    assign bus.tx_j  = sym_q[0];
    assign bus.tx_en = tx_en_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_kj_sync_tx.sv
// Directed bench for kj_sync_tx: frame symbol streams, reset abort and back-to-back starts.
module tb_kj_sync_tx;

    logic CLK;
    logic RST;
    int   checks;
    int   passed;

    kj_sync_tx_if #(.DATA_W(8)) bus ();

    kj_sync_tx #(
        .DATA_W    (8),
        .STUFF_LEN (6),
        .EOP_SE0   (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        string      syms;
        int         len;
        string      name;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(logic [7:0] d, string s, int l, string n);
        vec_t v;
        v.data = d;
        v.syms = s;
        v.len  = l;
        v.name = n;
        return v;
    endfunction

    function automatic string sym_char(logic k, logic j);
        if (k && j)  return "X";
        if (k)       return "K";
        if (j)       return "J";
        return "S";
    endfunction

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_str(string name, string act, string exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %s expected %s", name, act, exp);
    endtask

    // Called at the negedge showing the first frame symbol; returns at the first tx_en=0 sample.
    task automatic collect(output string s, output int n, output int busy_bad);
        s = "";
        n = 0;
        busy_bad = 0;
        while (bus.tx_en && n < 64) begin
            s = {s, sym_char(bus.tx_k, bus.tx_j)};
            if (!bus.busy || bus.done) busy_bad++;
            n++;
            @(negedge CLK);
        end
    endtask

    function automatic int idle_bits();
        return int'({bus.done, bus.busy, bus.tx_en, bus.tx_k, bus.tx_j});
    endfunction

    task automatic run_vec(vec_t v);
        string s;
        int    n;
        int    bb;
        bus.start = 1'b1;
        bus.data  = v.data;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.data  = 8'($urandom);
        collect(s, n, bb);
        check_str({v.name, "_syms"}, s, {"KJKJKJKK", v.syms, "SSJ"});
        check_int({v.name, "_txen_len"}, n, v.len);
        check_int({v.name, "_busy"}, bb, 0);
        check_int({v.name, "_done_cycle"}, idle_bits(), 5'b10001);
        @(negedge CLK);
        check_int({v.name, "_done_once"}, int'(bus.done), 0);
    endtask

    initial begin
        string s;
        int    n;
        int    bb;
        int    stray;

        checks = 0;
        passed = 0;
        vecs[0] = mk(8'h00, "JKJKJKJK",  19, "d00");
        vecs[1] = mk(8'hFF, "KKKKKKJJJ", 20, "dFF");
        vecs[2] = mk(8'h3F, "KKKKKKJKJ", 20, "d3F");
        vecs[3] = mk(8'hFC, "JKKKKKKKJ", 20, "dFC");
        vecs[4] = mk(8'hA5, "KJJKJJKK",  19, "dA5");
        vecs[5] = mk(8'h7E, "JJJJJJJKJ", 20, "d7E");
        vecs[6] = mk(8'h55, "KJJKKJJK",  19, "d55");

        RST       = 1'b0;
        bus.start = 1'b0;
        bus.data  = 8'h00;
        repeat (2) @(negedge CLK);
        check_int("reset_state", int'({bus.tx_en, bus.tx_k, bus.tx_j, bus.busy, bus.done}), 5'b00100);
        RST = 1'b1;
        @(negedge CLK);
        check_int("idle_after_release", idle_bits(), 5'b00001);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset asserted in the middle of the payload
        bus.start = 1'b1;
        bus.data  = 8'h00;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (10) @(negedge CLK);
        check_int("midframe_active", int'(bus.tx_en), 1);
        #2 RST = 1'b0;
        #1 check_int("midframe_reset", int'({bus.tx_en, bus.tx_k, bus.tx_j, bus.busy, bus.done}), 5'b00100);
        @(negedge CLK);
        RST = 1'b1;
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (bus.done || bus.tx_en || bus.busy) stray++;
        end
        check_int("no_done_after_reset", stray, 0);
        run_vec(vecs[0]);

        // start held high: second frame begins right after done, data latched at that accept
        bus.start = 1'b1;
        bus.data  = 8'hA5;
        @(negedge CLK);
        bus.data  = 8'h00;
        collect(s, n, bb);
        check_str("b2b_f1_syms", s, "KJKJKJKKKJJKJJKKSSJ");
        check_int("b2b_f1_len", n, 19);
        check_int("b2b_f1_busy", bb, 0);
        check_int("b2b_done_cycle", idle_bits(), 5'b10001);
        bus.data = 8'h3F;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.data  = 8'h00;
        check_int("b2b_f2_first_k", int'({bus.tx_en, bus.busy, bus.done, bus.tx_k, bus.tx_j}), 5'b11010);
        collect(s, n, bb);
        check_str("b2b_f2_syms", s, "KJKJKJKKKKKKKKJKJSSJ");
        check_int("b2b_f2_len", n, 20);
        check_int("b2b_f2_done", idle_bits(), 5'b10001);
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bus.tx_en || bus.busy || bus.done) stray++;
        end
        check_int("b2b_no_queued", stray, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/kj_sync_tx.md
Name: kj_sync_tx

Overview:
- Transmit-side counterpart of the circuito12 K/J sync receiver; drives k, j and the rx-enable line of a receiver or the loopback path.
- Serialises one parallel word per start request.
- Frame: 8-symbol SYNC pattern, then NRZI-encoded, bit-stuffed payload (LSB first), then SE0 end-of-packet, then one J symbol.
- Used as a stimulus source for circuito12 and as the TX half of the link.

Parameters:
- DATA_W, 8, payload width in bits (range 1..32).
- STUFF_LEN, 6, number of consecutive 1 bits after which a 0 is stuffed.
- EOP_SE0, 2, number of SE0 symbols in the end-of-packet.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- data  in  DATA_W  payload; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle before done.
- done  out  1  one-cycle pulse when the frame completes.
- tx_k  out  1  line K symbol.
- tx_j  out  1  line J symbol.
- tx_en  out  1  frame valid; connects to the receiver's rx_en.

Behaviour:
- All outputs are registered.
- Line encoding:
  - K = (tx_k=1, tx_j=0).
  - J = (0,1).
  - SE0 = (0,0).
  - (1,1) is never driven.
- Reset (RST=0, asynchronous, any state):
  - state=IDLE, tx_en=0, tx_k=0, tx_j=1 (idle J), busy=0, done=0.
  - All counters and the shift register clear.
  - An in-flight frame is abandoned. No done pulse is produced after reset release.
- IDLE:
  - Outputs hold J with tx_en=0.
  - start=1 at edge N: latch data, and from edge N+1 drive the first SYNC symbol with tx_en=1 and busy=1.
- SYNC:
  - 8 cycles driving K J K J K J K K in that order.
  - Line state after SYNC is K.
- DATA:
  - One symbol per cycle, LSB first.
  - Bit 0: toggle the line state (K<->J). Bit 1: hold the line state.
  - Ones counter:
    - Cleared on entering DATA.
    - Incremented on each 1 bit; cleared on each 0 bit, including stuffed bits.
  - When the counter reaches STUFF_LEN, the next cycle carries a stuffed 0 (toggle). The payload bit index does not advance in that cycle.
  - A stuff that falls due after the last payload bit is still emitted before EOP.
  - DATA length = DATA_W + number of stuffed bits.
- EOP:
  - EOP_SE0 cycles of SE0 with tx_en=1.
  - Then one cycle of J with tx_en=1.
- DONE:
  - The next cycle returns to IDLE: tx_en=0, line J, busy=0, done=1 for exactly that cycle.
  - A start in that same cycle is accepted (back-to-back frames allowed). Its SYNC begins on the following edge.
- Handshake rules:
  - start while busy=1 is ignored and not queued.
  - data is don't-care outside the accepting cycle.
- Latency: start edge to first K is 1 cycle. Total tx_en=1 cycles = 8 + DATA_W + stuffs + EOP_SE0 + 1.
- Widths: bit counter is clog2(DATA_W+1) bits; ones counter is clog2(STUFF_LEN+1) bits; no wrap is possible within a frame.

Decomposition:
- Shared package kj_pkg contains:
  - State enum {IDLE, SYNC, DATA, EOP, LAST_J}.
  - Symbol constants SYM_K=2'b10, SYM_J=2'b01, SYM_SE0=2'b00.
  - SYNC_PATTERN constant as 8 symbols.
- The same package is imported by receiver-side checkers.
- One sub-module, kj_nrzi_stuffer: bit in, valid, ones counter, stuff request, and current line symbol. It keeps the NRZI and stuffing logic separate from the frame FSM.

Test Plan:
- Reset mid-frame: assert RST low during the DATA phase -> same cycle: tx_en=0, tx_k=0, tx_j=1, busy=0; no done pulse after release.
- data=8'h00, start one cycle: SYNC symbols KJKJKJKK; data symbols J K J K J K J K; SE0 SE0; J; done pulses 1 cycle later. tx_en is high for exactly 19 cycles.
- data=8'hFF: data symbols K K K K K K, then stuffed J, then J J (9 symbols); EOP follows. tx_en is high for 20 cycles.
- data=8'h3F (six ones then 0,0): K×6, stuffed J, then K, J (9 symbols); ones counter is cleared by the stuff.
- start held high through a whole frame with data=8'hA5: exactly one frame per accepted start; the second frame's SYNC begins the cycle after done; no start is accepted while busy.
- Connect to circuito12 (k, j, rx_en) with data=8'h00 -> receiver synced_d asserts after SYNC and sync_err_d stays 0 for the whole frame.
